// File: rtl/riscv_control_unit_if.sv
// Control-unit boundary: instruction/flags in from fetch and ALU, datapath controls out.
// The control unit uses the slave modport; whatever feeds it uses master.
interface riscv_control_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] Instr;
    logic            Zero;
    logic            Negative;
    logic [1:0]      PCSrc;
    logic [1:0]      ResultSrc;
    logic            MemWrite;
    logic            ALUSrc;
    logic            RegWrite;
    logic [4:0]      ALUControl;
    logic [2:0]      ImmSrc;

    modport master (
        output Instr, Zero, Negative,
        input  PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc
    );

    modport slave (
        input  Instr, Zero, Negative,
        output PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc
    );
endinterface

// File: rtl/riscv_control_unit.sv
// RV32I main + ALU decoder. Instruction is registered each cycle; controls decode
// from the register, and PCSrc also follows the live Zero/Negative flags for branches.
module riscv_control_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_control_unit_if.slave  bus
);
    localparam int unsigned ALU_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00001;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'b00010;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_XOR  = 5'b00100;
    localparam logic [ALU_W-1:0] ALU_SLL  = 5'b00101;
    localparam logic [ALU_W-1:0] ALU_SRL  = 5'b00110;
    localparam logic [ALU_W-1:0] ALU_SRA  = 5'b00111;
    localparam logic [ALU_W-1:0] ALU_SLT  = 5'b01000;
    localparam logic [ALU_W-1:0] ALU_SLTU = 5'b01001;

    logic [XLEN-1:0] ir;

    // Instruction register; reset value is an illegal opcode so all controls idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ir <= '0;
        else        ir <= bus.Instr;
    end

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign f7b5   = ir[30];

    logic unused_ir_fields;
    assign unused_ir_fields = ^{ir[XLEN-1:31], ir[29:15], ir[11:7]};

    // Shared R/I arithmetic map; alt selects SUB/SRA where the encoding allows it.
    function automatic logic [ALU_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    logic [1:0]       pc_src;
    logic [1:0]       result_src;
    logic             mem_write;
    logic             alu_src;
    logic             reg_write;
    logic [ALU_W-1:0] alu_control;
    logic [2:0]       imm_src;
    logic             taken;

    always_comb begin
        pc_src      = 2'b00;
        result_src  = 2'b00;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        alu_control = ALU_ADD;
        imm_src     = 3'b000;
        taken       = 1'b0;
        case (opcode)
            OP_R: begin
                reg_write   = 1'b1;
                alu_control = arith_op(funct3, f7b5);
            end
            OP_I: begin
                reg_write   = 1'b1;
                alu_src     = 1'b1;
                alu_control = arith_op(funct3, f7b5 & (funct3 != 3'b000));
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = 3'b001;
            end
            // Unsigned compares use SLTU, so "less than" shows up as a non-zero result.
            OP_BRANCH: begin
                imm_src = 3'b010;
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  taken = bus.Zero;      end
                    3'b001: begin alu_control = ALU_SUB;  taken = !bus.Zero;     end
                    3'b100: begin alu_control = ALU_SUB;  taken = bus.Negative;  end
                    3'b101: begin alu_control = ALU_SUB;  taken = !bus.Negative; end
                    3'b110: begin alu_control = ALU_SLTU; taken = !bus.Zero;     end
                    3'b111: begin alu_control = ALU_SLTU; taken = bus.Zero;      end
                    default: taken = 1'b0;
                endcase
                pc_src = taken ? 2'b01 : 2'b00;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_src    = 3'b011;
                result_src = 2'b10;
                pc_src     = 2'b01;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b10;
                pc_src     = 2'b10;
            end
            OP_LUI: begin
                reg_write  = 1'b1;
                imm_src    = 3'b100;
                result_src = 2'b11;
            end
            default: ;
        endcase
    end

    assign bus.PCSrc      = pc_src;
    assign bus.ResultSrc  = result_src;
    assign bus.MemWrite   = mem_write;
    assign bus.ALUSrc     = alu_src;
    assign bus.RegWrite   = reg_write;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src;
endmodule

// File: tb/tb_riscv_control_unit.sv
// Self-checking bench for riscv_control_unit: directed cases plus random instructions
// compared against a mnemonic-level reference decoder.
module tb_riscv_control_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] m_ir;

    riscv_control_unit_if #(.XLEN(32)) bus ();

    riscv_control_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decoder: instruction -> mnemonic -> control word
    // packed as {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc}.
    function automatic logic [14:0] model(input logic [31:0] ir, input logic z, input logic n);
        string alu_names[10] = '{"ADD","SUB","AND","OR","XOR","SLL","SRL","SRA","SLT","SLTU"};
        string f3_names[8]   = '{"ADD","SLL","SLT","SLTU","XOR","SRL","OR","AND"};
        string op_name = "";
        logic [1:0] pc = 2'd0;
        logic [1:0] rs = 2'd0;
        logic mw = 1'b0;
        logic as = 1'b0;
        logic rw = 1'b0;
        logic taken = 1'b0;
        logic [4:0] ac = 5'd0;
        logic [2:0] is = 3'd0;
        logic [2:0] f3 = ir[14:12];
        logic alt = ir[30];
        case (ir[6:0])
            7'b0110011: begin
                rw = 1'b1;
                op_name = f3_names[f3];
                if (alt && op_name == "ADD") op_name = "SUB";
                if (alt && op_name == "SRL") op_name = "SRA";
            end
            7'b0010011: begin
                rw = 1'b1; as = 1'b1;
                op_name = f3_names[f3];
                if (alt && op_name == "SRL") op_name = "SRA";
            end
            7'b0000011: begin rw = 1'b1; as = 1'b1; rs = 2'd1; op_name = "ADD"; end
            7'b0100011: begin mw = 1'b1; as = 1'b1; is = 3'd1; op_name = "ADD"; end
            7'b1100011: begin
                is = 3'd2;
                case (f3)
                    3'd0: begin op_name = "SUB";  taken = z;  end
                    3'd1: begin op_name = "SUB";  taken = !z; end
                    3'd4: begin op_name = "SUB";  taken = n;  end
                    3'd5: begin op_name = "SUB";  taken = !n; end
                    3'd6: begin op_name = "SLTU"; taken = !z; end
                    3'd7: begin op_name = "SLTU"; taken = z;  end
                    default: taken = 1'b0;
                endcase
                pc = taken ? 2'd1 : 2'd0;
            end
            7'b1101111: begin rw = 1'b1; is = 3'd3; rs = 2'd2; pc = 2'd1; end
            7'b1100111: begin rw = 1'b1; as = 1'b1; op_name = "ADD"; rs = 2'd2; pc = 2'd2; end
            7'b0110111: begin rw = 1'b1; is = 3'd4; rs = 2'd3; end
            default: ;
        endcase
        for (int i = 0; i < 10; i++)
            if (alu_names[i] == op_name) ac = 5'(i);
        return {pc, rs, mw, as, rw, ac, is};
    endfunction

    function automatic logic [14:0] observed();
        return {bus.PCSrc, bus.ResultSrc, bus.MemWrite, bus.ALUSrc, bus.RegWrite,
                bus.ALUControl, bus.ImmSrc};
    endfunction

    // Present an instruction, clock it in, and sample just after the edge.
    task automatic apply(input logic [31:0] instr);
        bus.Instr = instr;
        @(posedge clk);
        m_ir = rst_n ? instr : 32'h0;
        #1;
    endtask

    task automatic check_word(input string tag);
        check(tag, 32'(observed()), 32'(model(m_ir, bus.Zero, bus.Negative)));
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops[11];
        n_checks = 0;
        n_fail   = 0;
        m_ir     = 32'h0;
        rst_n    = 1'b0;
        bus.Zero = 1'b0;
        bus.Negative = 1'b0;
        bus.Instr = 32'h005302B3;

        // Reset holds everything at zero even with a legal instruction presented
        apply(32'h005302B3);
        apply(32'h005302B3);
        check("reset_all_zero", 32'(observed()), 32'h0);
        rst_n = 1'b1;
        apply(32'h005302B3);
        check("add_pcsrc", 32'(bus.PCSrc), 32'd0);
        check("add_alu", 32'(bus.ALUControl), 32'd0);
        check("add_regwrite", 32'(bus.RegWrite), 32'd1);

        apply(32'h407302B3);
        check("sub_alu", 32'(bus.ALUControl), 32'd1);
        apply(32'h00530293);
        check("addi_alusrc", 32'(bus.ALUSrc), 32'd1);
        check("addi_alu", 32'(bus.ALUControl), 32'd0);
        check("addi_imm", 32'(bus.ImmSrc), 32'd0);
        check("addi_regwrite", 32'(bus.RegWrite), 32'd1);
        apply(32'h40535293);
        check("srai_alu", 32'(bus.ALUControl), 32'd7);
        apply(32'h40030293);
        check("addi_f7b5_ignored", 32'(bus.ALUControl), 32'd0);

        apply(32'h00032283);
        check("lw_result", 32'(bus.ResultSrc), 32'd1);
        check("lw_memwrite", 32'(bus.MemWrite), 32'd0);
        check("lw_regwrite", 32'(bus.RegWrite), 32'd1);
        apply(32'h00532023);
        check("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        check("sw_alusrc", 32'(bus.ALUSrc), 32'd1);
        check("sw_imm", 32'(bus.ImmSrc), 32'd1);
        check("sw_regwrite", 32'(bus.RegWrite), 32'd0);

        bus.Zero = 1'b1;
        apply(32'h00530063);
        check("beq_taken", 32'(bus.PCSrc), 32'd1);
        bus.Zero = 1'b0; #1;
        check("beq_not_taken", 32'(bus.PCSrc), 32'd0);
        bus.Negative = 1'b1;
        apply(32'h00534063);
        check("blt_taken", 32'(bus.PCSrc), 32'd1);
        bus.Negative = 1'b0; #1;
        check("blt_not_taken", 32'(bus.PCSrc), 32'd0);
        bus.Zero = 1'b1;
        apply(32'h00537063);
        check("bgeu_taken", 32'(bus.PCSrc), 32'd1);
        check("bgeu_alu", 32'(bus.ALUControl), 32'd9);
        bus.Zero = 1'b0; #1;
        check("bgeu_toggle", 32'(bus.PCSrc), 32'd0);
        bus.Zero = 1'b1; #1;
        check("bgeu_toggle_back", 32'(bus.PCSrc), 32'd1);
        bus.Zero = 1'b0;

        apply(32'h0000006F);
        check("jal_pcsrc", 32'(bus.PCSrc), 32'd1);
        check("jal_regwrite", 32'(bus.RegWrite), 32'd1);
        check("jal_result", 32'(bus.ResultSrc), 32'd2);
        check("jal_imm", 32'(bus.ImmSrc), 32'd3);
        apply(32'h00008067);
        check("jalr_pcsrc", 32'(bus.PCSrc), 32'd2);
        check("jalr_regwrite", 32'(bus.RegWrite), 32'd1);
        check("jalr_alusrc", 32'(bus.ALUSrc), 32'd1);
        apply(32'h00000037);
        check("lui_result", 32'(bus.ResultSrc), 32'd3);
        check("lui_regwrite", 32'(bus.RegWrite), 32'd1);
        check("lui_imm", 32'(bus.ImmSrc), 32'd4);
        apply(32'h00000017);
        check("auipc_all_zero", 32'(observed()), 32'h0);

        // Asynchronous reset between edges while a JAL is held
        apply(32'h0000006F);
        check("jal_before_reset", 32'(bus.PCSrc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_zero", 32'(observed()), 32'h0);
        m_ir = 32'h0;
        rst_n = 1'b1;
        #1;
        check("post_reset_still_zero", 32'(observed()), 32'h0);
        apply(32'h00000037);
        check_word("recover_lui");

        // Random instructions over legal, illegal and arbitrary opcodes
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0};
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            ops[10] = 7'($urandom_range(0, 127));
            r[6:0] = ops[$urandom_range(0, 10)];
            bus.Zero     = 1'($urandom_range(0, 1));
            bus.Negative = 1'($urandom_range(0, 1));
            apply(r);
            check_word("rand_decode");
            bus.Zero     = 1'($urandom_range(0, 1));
            bus.Negative = 1'($urandom_range(0, 1));
            #1;
            check_word("rand_flags");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
